// File: rtl/gpio_pkg.sv
// Register map and board I/O widths shared by the GPIO peripheral and its debouncer users.
package gpio_pkg;
   localparam int LED_W = 10;
   localparam int SW_W  = 10;
   localparam int KEY_W = 4;

   typedef enum logic [2:0] {
      IDX_LED_OUT    = 3'd0,
      IDX_LED_SET    = 3'd1,
      IDX_LED_CLR    = 3'd2,
      IDX_SW_IN      = 3'd3,
      IDX_KEY_IN     = 3'd4,
      IDX_KEY_EDGE   = 3'd5,
      IDX_BLINK_DIV  = 3'd6,
      IDX_BLINK_MASK = 3'd7
   } reg_idx_e;

   function automatic logic [LED_W-1:0] blink_apply(input logic [LED_W-1:0] leds,
                                                    input logic [LED_W-1:0] mask,
                                                    input logic             phase);
      return phase ? (leds ^ mask) : leds;
   endfunction
endpackage

// File: rtl/gpio_peripheral_debounce_sync.sv
// Two-flop synchronizer followed by a tick-sampled debouncer; a bit only changes
// when two consecutive tick samples agree.
module debounce_sync #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);
   logic [WIDTH-1:0] sync1_q, sync2_q, sample_q, stable_q;
   logic [WIDTH-1:0] sample_d, stable_d, agree_s;

   // Sample and per-bit stable update on each tick
   always_comb begin
      agree_s  = ~(sync2_q ^ sample_q);
      sample_d = sample_q;
      stable_d = stable_q;
      if (tick_i) begin
         sample_d = sync2_q;
         stable_d = (stable_q & ~agree_s) | (sync2_q & agree_s);
      end else begin
         sample_d = sample_q;
         stable_d = stable_q;
      end
   end

   // Synchronizer and debounce state registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q  <= RESET_VAL;
         sync2_q  <= RESET_VAL;
         sample_q <= RESET_VAL;
         stable_q <= RESET_VAL;
      end else begin
         sync1_q  <= din_i;
         sync2_q  <= sync1_q;
         sample_q <= sample_d;
         stable_q <= stable_d;
      end
   end

   assign dout_o = stable_q;
endmodule

// File: rtl/gpio_peripheral.sv
// Memory-mapped GPIO block: LED register with set/clear/blink, debounced switches and keys
// with sticky key-press flags. Read data is registered from the addressed register.
module gpio_peripheral
   import gpio_pkg::*;
#(
   parameter int DATA_SIZE       = 32,
   parameter int ADDR_SIZE       = 10,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [ADDR_SIZE-1:0] DADDR,
   input  logic                 D_RW,
   input  logic [DATA_SIZE-1:0] DDATA_W,
   output logic [DATA_SIZE-1:0] DDATA_R,
   input  logic [SW_W-1:0]      SW,
   input  logic [KEY_W-1:0]     KEY,
   output logic [LED_W-1:0]     LEDR
);
   localparam logic [31:0] TICK_LAST = 32'(DEBOUNCE_CYCLES - 1);

   reg_idx_e         idx_s;
   logic             wr_s, tick_s, unused_s;
   logic [SW_W-1:0]  sw_db_s;
   logic [KEY_W-1:0] key_db_s, key_pressed_s, edge_clr_s;

   logic [LED_W-1:0]     led_out_q, led_out_d, blink_mask_q, blink_mask_d, ledr_q;
   logic [KEY_W-1:0]     key_edge_q, key_edge_d, key_prev_q;
   logic [31:0]          blink_div_q, blink_div_d, blink_cnt_q, blink_cnt_d;
   logic [31:0]          tick_cnt_q, tick_cnt_d;
   logic                 phase_q, phase_d;
   logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;

   assign idx_s         = reg_idx_e'(DADDR[2:0]);
   assign wr_s          = DADDR[ADDR_SIZE-1] & D_RW;
   assign tick_s        = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d    = tick_s ? 32'd0 : (tick_cnt_q + 32'd1);
   assign key_pressed_s = ~key_db_s;
   assign edge_clr_s    = (wr_s && (idx_s == IDX_KEY_EDGE)) ? DDATA_W[KEY_W-1:0] : {KEY_W{1'b0}};
   assign unused_s      = ^{DADDR[ADDR_SIZE-2:3], DDATA_W};

   debounce_sync #(.WIDTH(SW_W), .RESET_VAL({SW_W{1'b0}})) u_sw_db (
      .clk_i(CLK), .rst_ni(RESET_N), .tick_i(tick_s), .din_i(SW), .dout_o(sw_db_s)
   );

   debounce_sync #(.WIDTH(KEY_W), .RESET_VAL({KEY_W{1'b1}})) u_key_db (
      .clk_i(CLK), .rst_ni(RESET_N), .tick_i(tick_s), .din_i(KEY), .dout_o(key_db_s)
   );

   // LED_OUT / BLINK_MASK writes; set wins over clear on KEY_EDGE
   always_comb begin
      led_out_d    = led_out_q;
      blink_mask_d = blink_mask_q;
      key_edge_d   = (key_edge_q & ~edge_clr_s) | (key_pressed_s & ~key_prev_q);
      if (wr_s) begin
         case (idx_s)
            IDX_LED_OUT:    led_out_d    = DDATA_W[LED_W-1:0];
            IDX_LED_SET:    led_out_d    = led_out_q | DDATA_W[LED_W-1:0];
            IDX_LED_CLR:    led_out_d    = led_out_q & ~DDATA_W[LED_W-1:0];
            IDX_BLINK_MASK: blink_mask_d = DDATA_W[LED_W-1:0];
            default:        led_out_d    = led_out_q;
         endcase
      end else begin
         led_out_d = led_out_q;
      end
   end

   // Blink divider: a write restarts the count but keeps the phase
   always_comb begin
      blink_div_d = blink_div_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (wr_s && (idx_s == IDX_BLINK_DIV)) begin
         blink_div_d = DDATA_W[31:0];
         blink_cnt_d = 32'd0;
      end else if (blink_div_q != 32'd0) begin
         if (blink_cnt_q == (blink_div_q - 32'd1)) begin
            blink_cnt_d = 32'd0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 32'd1;
         end
      end else begin
         blink_cnt_d = 32'd0;
         phase_d     = 1'b0;
      end
   end

   // Read mux over pre-write register values
   always_comb begin
      rd_data_d = {DATA_SIZE{1'b0}};
      case (idx_s)
         IDX_LED_OUT:    rd_data_d[LED_W-1:0] = led_out_q;
         IDX_SW_IN:      rd_data_d[SW_W-1:0]  = sw_db_s;
         IDX_KEY_IN:     rd_data_d[KEY_W-1:0] = key_pressed_s;
         IDX_KEY_EDGE:   rd_data_d[KEY_W-1:0] = key_edge_q;
         IDX_BLINK_DIV:  rd_data_d[31:0]      = blink_div_q;
         IDX_BLINK_MASK: rd_data_d[LED_W-1:0] = blink_mask_q;
         default:        rd_data_d            = {DATA_SIZE{1'b0}};
      endcase
   end

   // All peripheral state
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         led_out_q    <= {LED_W{1'b0}};
         blink_mask_q <= {LED_W{1'b0}};
         key_edge_q   <= {KEY_W{1'b0}};
         key_prev_q   <= {KEY_W{1'b0}};
         blink_div_q  <= 32'd0;
         blink_cnt_q  <= 32'd0;
         phase_q      <= 1'b0;
         tick_cnt_q   <= 32'd0;
         rd_data_q    <= {DATA_SIZE{1'b0}};
         ledr_q       <= {LED_W{1'b0}};
      end else begin
         led_out_q    <= led_out_d;
         blink_mask_q <= blink_mask_d;
         key_edge_q   <= key_edge_d;
         key_prev_q   <= key_pressed_s;
         blink_div_q  <= blink_div_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         tick_cnt_q   <= tick_cnt_d;
         rd_data_q    <= rd_data_d;
         ledr_q       <= blink_apply(led_out_q, blink_mask_q, phase_q);
      end
   end

   assign DDATA_R = rd_data_q;
   assign LEDR    = ledr_q;
endmodule

// File: tb/tb_gpio_peripheral.sv
// Directed bench for gpio_peripheral: a per-cycle behavioural model checked on every
// falling edge, plus literal expectations at the key points of each scenario.
module tb_gpio_peripheral;
   localparam int DEB = 4;

   logic        CLK = 1'b0;
   logic        RESET_N, D_RW;
   logic [9:0]  DADDR;
   logic [31:0] DDATA_W, DDATA_R;
   logic [9:0]  SW, LEDR;
   logic [3:0]  KEY;

   int total = 0;
   int bad   = 0;

   gpio_peripheral #(.DATA_SIZE(32), .ADDR_SIZE(10), .DEBOUNCE_CYCLES(DEB)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .DADDR(DADDR), .D_RW(D_RW), .DDATA_W(DDATA_W),
      .DDATA_R(DDATA_R), .SW(SW), .KEY(KEY), .LEDR(LEDR)
   );

   always #5 CLK = ~CLK;

   // Model state: values the DUT must hold after the most recent rising edge
   logic        m_valid = 1'b0;
   logic [9:0]  m_led, m_mask, m_ledr, m_sw_s1, m_sw_s2, m_sw_samp, m_sw_db;
   logic [3:0]  m_key_s1, m_key_s2, m_key_samp, m_key_db, m_edge, m_prev, m_set_next;
   logic [31:0] m_div, m_rd;
   logic        m_phase, m_base;
   int unsigned m_n, m_k;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance the model across the coming rising edge using the inputs now applied
   task automatic model_step();
      logic [2:0] idx;
      logic       wr;
      logic [3:0] pressed, clr;
      logic [9:0] ag_sw;
      logic [3:0] ag_key;
      if (!RESET_N) begin
         m_led = 10'd0; m_mask = 10'd0; m_ledr = 10'd0; m_rd = 32'd0; m_div = 32'd0;
         m_phase = 1'b0; m_base = 1'b0; m_n = 0; m_k = 0; m_edge = 4'd0; m_prev = 4'd0;
         m_sw_s1 = 10'd0; m_sw_s2 = 10'd0; m_sw_samp = 10'd0; m_sw_db = 10'd0;
         m_key_s1 = 4'hF; m_key_s2 = 4'hF; m_key_samp = 4'hF; m_key_db = 4'hF;
         m_set_next = 4'd0; m_valid = 1'b1;
      end else begin
         idx = DADDR[2:0];
         wr  = DADDR[9] & D_RW;
         case (idx)
            3'd0:    m_rd = {22'd0, m_led};
            3'd3:    m_rd = {22'd0, m_sw_db};
            3'd4:    m_rd = {28'd0, ~m_key_db};
            3'd5:    m_rd = {28'd0, m_edge};
            3'd6:    m_rd = m_div;
            3'd7:    m_rd = {22'd0, m_mask};
            default: m_rd = 32'd0;
         endcase
         m_ledr  = m_led ^ (m_phase ? m_mask : 10'd0);
         pressed = ~m_key_db;
         clr     = (wr && idx == 3'd5) ? DDATA_W[3:0] : 4'd0;
         m_edge  = (m_edge & ~clr) | (pressed & ~m_prev);
         m_prev  = pressed;
         if (wr) begin
            case (idx)
               3'd0:    m_led  = DDATA_W[9:0];
               3'd1:    m_led  = m_led | DDATA_W[9:0];
               3'd2:    m_led  = m_led & ~DDATA_W[9:0];
               3'd7:    m_mask = DDATA_W[9:0];
               default: ;
            endcase
         end
         // Phase = phase at last divider write, flipped once per completed half-period
         if (wr && idx == 3'd6) begin
            m_base = m_phase; m_n = 0; m_div = DDATA_W;
         end else if (m_div != 32'd0) begin
            m_n++;
            m_phase = m_base ^ (((32'(m_n) / m_div) % 32'd2) != 32'd0);
         end else begin
            m_phase = 1'b0;
         end
         m_k++;
         if (m_k % DEB == 0) begin
            ag_sw      = ~(m_sw_s2 ^ m_sw_samp);
            m_sw_db    = (m_sw_db & ~ag_sw) | (m_sw_s2 & ag_sw);
            m_sw_samp  = m_sw_s2;
            ag_key     = ~(m_key_s2 ^ m_key_samp);
            m_key_db   = (m_key_db & ~ag_key) | (m_key_s2 & ag_key);
            m_key_samp = m_key_s2;
         end
         m_sw_s2 = m_sw_s1;   m_sw_s1 = SW;
         m_key_s2 = m_key_s1; m_key_s1 = KEY;
         m_set_next = ~m_key_db & ~m_prev;
      end
   endtask

   // Per-cycle compare against the model, then step it
   initial begin
      forever begin
         @(negedge CLK);
         if (m_valid) begin
            check("ledr_model", 32'(LEDR), 32'(m_ledr));
            check("ddata_r_model", DDATA_R, m_rd);
         end
         model_step();
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d);
      DADDR = a; D_RW = 1'b1; DDATA_W = d;
      @(posedge CLK); #1;
      D_RW = 1'b0; DDATA_W = 32'd0;
   endtask

   task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string nm);
      DADDR = a; D_RW = 1'b0;
      @(posedge CLK); #1;
      check(nm, DDATA_R, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      RESET_N = 1'b0; D_RW = 1'b0; DADDR = 10'd0; DDATA_W = 32'd0; SW = 10'd0; KEY = 4'hF;
      idle(3);
      check("reset_ledr", 32'(LEDR), 32'd0);
      check("reset_ddata_r", DDATA_R, 32'd0);
      RESET_N = 1'b1;
      idle(2);

      // LED load / clear / set
      wr(10'h200, 32'h3FF);
      wr(10'h202, 32'h00F);
      idle(1);
      check("ledr_after_clr", 32'(LEDR), 32'h3F0);
      rd(10'h200, 32'h3F0, "rd_led_out");
      wr(10'h201, 32'h005);
      rd(10'h201, 32'h0, "rd_led_set_zero");
      rd(10'h200, 32'h3F5, "rd_led_after_set");

      // Deselected writes ignored, aliases honoured, upper bits zero
      wr(10'h000, 32'h000);
      wr(10'h1FF, 32'h3FF);
      rd(10'h200, 32'h3F5, "deselected_write");
      rd(10'h207, 32'h0, "deselected_mask");
      wr(10'h3F8, 32'h0AA);
      rd(10'h200, 32'h0AA, "alias_write");
      wr(10'h200, 32'hFFFF_FFFF);
      rd(10'h200, 32'h3FF, "upper_bits_zero");
      DADDR = 10'h200; D_RW = 1'b1; DDATA_W = 32'h123;
      @(posedge CLK); #1;
      check("read_during_write", DDATA_R, 32'h3FF);
      D_RW = 1'b0;
      rd(10'h200, 32'h123, "after_rdw");
      wr(10'h200, 32'h0);

      // Blink half-period 4, then disable
      wr(10'h207, 32'h001);
      wr(10'h206, 32'd4);
      idle(5); check("blink_on_1", 32'(LEDR), 32'h001);
      idle(4); check("blink_off", 32'(LEDR), 32'h000);
      idle(4); check("blink_on_2", 32'(LEDR), 32'h001);
      wr(10'h206, 32'd0);
      idle(2); check("blink_disabled", 32'(LEDR), 32'h000);
      idle(10); check("blink_stays_off", 32'(LEDR), 32'h000);
      rd(10'h206, 32'd0, "rd_blink_div");
      wr(10'h207, 32'h000);

      // Switch glitch filtered, held value accepted
      SW = 10'h155; idle(3); SW = 10'h000;
      idle(12);
      rd(10'h203, 32'h0, "sw_glitch");
      SW = 10'h155;
      idle(12);
      rd(10'h203, 32'h155, "sw_held");

      // Key press, edge flag, clear, set-wins collision
      KEY = 4'b1011;
      idle(14);
      rd(10'h204, 32'h4, "key_in");
      rd(10'h205, 32'h4, "key_edge");
      wr(10'h205, 32'h4);
      rd(10'h205, 32'h0, "key_edge_clr");
      KEY = 4'hF;
      idle(14);
      rd(10'h205, 32'h0, "no_edge_on_release");
      KEY = 4'b1011;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (m_set_next[2]) begin
            found = 1'b1;
            break;
         end
         idle(1);
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL key_set_wait: got no press edge expected one within 40 cycles");
      end
      wr(10'h205, 32'h4);
      rd(10'h205, 32'h4, "set_wins");
      wr(10'h205, 32'h4);
      rd(10'h205, 32'h0, "clr_after_set");

      // Reset during blink with a key held
      wr(10'h207, 32'h3FF);
      wr(10'h200, 32'h0F0);
      wr(10'h206, 32'd2);
      KEY = 4'b1110;
      idle(14);
      RESET_N = 1'b0;
      idle(1);
      check("midrun_reset_ledr", 32'(LEDR), 32'h0);
      check("midrun_reset_ddata", DDATA_R, 32'h0);
      KEY = 4'hF;
      idle(2);
      RESET_N = 1'b1;
      idle(14);
      rd(10'h205, 32'h0, "edge_after_reset");
      rd(10'h204, 32'h0, "key_after_reset");
      rd(10'h206, 32'h0, "div_after_reset");
      check("ledr_after_reset", 32'(LEDR), 32'h0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
